// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, the x0 register index and the round-robin pointer step for the writeback arbiter.
package wb_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;
  function automatic int next_ptr(input int g, input int nreq);
    return (g + 1) % nreq;
  endfunction
endpackage

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: NREQ-wide round-robin arbiter, scanning from ptr; ptr moves past the winner on advance.
module wb_rr_arbiter
  import wb_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            hold,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   ptr
);
  logic [PW-1:0] g;
  logic [PW-1:0] idx;
  logic found;
  always_comb begin
    grant = '0;
    g = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!hold && !found && req[idx]) begin
        grant[idx] = 1'b1;
        g = idx;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (advance) ptr <= PW'(next_ptr(int'(g), NREQ));
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin share of the register-file write port with a registered output stage and rs/rt forwarding.
// Define WB_STATS_EN to add the commit/conflict/x0-drop counters.
module wb_arbiter #(
  parameter int NREQ = 2,
  parameter int ADDR_W = wb_pkg::ADDR_W,
  parameter int DATA_W = wb_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ADDR_W-1:0] req_rd,
  input  logic [NREQ*DATA_W-1:0] req_data,
  input  logic                   wb_hold,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_rd,
  output logic [DATA_W-1:0]      rf_wdata,
  input  logic [ADDR_W-1:0]      rs_addr,
  input  logic [ADDR_W-1:0]      rt_addr,
  input  logic [DATA_W-1:0]      rf_rs_data,
  input  logic [DATA_W-1:0]      rf_rt_data,
  output logic [DATA_W-1:0]      rs_data,
  output logic [DATA_W-1:0]      rt_data
`ifdef WB_STATS_EN
  ,
  output logic [31:0]            stat_commits,
  output logic [31:0]            stat_conflicts,
  output logic [31:0]            stat_x0_drops
`endif
);
  import wb_pkg::*;
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam logic [ADDR_W-1:0] RD_ZERO = ADDR_W'(REG_ZERO);
  logic transfer;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic [PW-1:0] ptr;
  assign transfer = |(req_valid & req_ready);
  // reset folds into hold so no requester sees ready while rst is high
  wb_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk(clk),
    .rst(rst),
    .req(req_valid),
    .hold(wb_hold | rst),
    .advance(transfer),
    .grant(req_ready),
    .ptr(ptr)
  );
  always_comb begin
    sel_rd = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_rd = req_ready[i] ? req_rd[i*ADDR_W +: ADDR_W] : sel_rd;
      sel_data = req_ready[i] ? req_data[i*DATA_W +: DATA_W] : sel_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_rd <= '0;
      rf_wdata <= '0;
    end else if (transfer) begin
      rf_we <= sel_rd != RD_ZERO;
      rf_rd <= sel_rd;
      rf_wdata <= sel_data;
    end else begin
      rf_we <= 1'b0;
    end
  end
  assign rs_data = (rf_we && rf_rd == rs_addr && rs_addr != RD_ZERO) ? rf_wdata : rf_rs_data;
  assign rt_data = (rf_we && rf_rd == rt_addr && rt_addr != RD_ZERO) ? rf_wdata : rf_rt_data;
`ifdef WB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_commits <= '0;
      stat_conflicts <= '0;
      stat_x0_drops <= '0;
    end else begin
      stat_commits <= stat_commits + 32'(rf_we);
      stat_conflicts <= stat_conflicts + 32'(!wb_hold && $countones(req_valid) > 1);
      stat_x0_drops <= stat_x0_drops + 32'(transfer && sel_rd == RD_ZERO);
    end
  end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed checks of grant order, output stage, x0 drop, forwarding, hold and reset.
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req_valid = '0;
  logic [1:0] req_ready;
  logic [4:0] rd0 = '0, rd1 = '0;
  logic [31:0] d0 = '0, d1 = '0;
  logic wb_hold = 1'b0;
  logic rf_we;
  logic [4:0] rf_rd;
  logic [31:0] rf_wdata;
  logic [4:0] rs_addr = '0, rt_addr = '0;
  logic [31:0] rf_rs_data = '0, rf_rt_data = '0;
  logic [31:0] rs_data, rt_data;
  int checks = 0;
  int errors = 0;
`ifdef WB_STATS_EN
  logic [31:0] stat_commits, stat_conflicts, stat_x0_drops;
`endif
  always #5 clk = ~clk;
  wb_arbiter #(.NREQ(2), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rd({rd1, rd0}),
    .req_data({d1, d0}),
    .wb_hold(wb_hold),
    .rf_we(rf_we),
    .rf_rd(rf_rd),
    .rf_wdata(rf_wdata),
    .rs_addr(rs_addr),
    .rt_addr(rt_addr),
    .rf_rs_data(rf_rs_data),
    .rf_rt_data(rf_rt_data),
    .rs_data(rs_data),
    .rt_data(rt_data)
`ifdef WB_STATS_EN
    ,
    .stat_commits(stat_commits),
    .stat_conflicts(stat_conflicts),
    .stat_x0_drops(stat_x0_drops)
`endif
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    req_valid = 2'b11;
    rd0 = 5'd1;
    rd1 = 5'd2;
    tick();
    tick();
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", req_ready); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", rf_we); end
    checks++; if (rf_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d want 0", rf_rd); end
    checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", rf_wdata); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_first_grant got %b want 01", req_ready); end
    req_valid = 2'b00;
    tick();
  endtask
  task automatic test_single;
    req_valid = 2'b01;
    rd0 = 5'd5;
    d0 = 32'h12345678;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    #1;
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL single_we got %b want 1", rf_we); end
    checks++; if (rf_rd !== 5'd5) begin errors++; $display("FAIL single_rd got %0d want 5", rf_rd); end
    checks++; if (rf_wdata !== 32'h12345678) begin errors++; $display("FAIL single_wdata got %h want 12345678", rf_wdata); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_we_clear got %b want 0", rf_we); end
    checks++; if (rf_rd !== 5'd5) begin errors++; $display("FAIL single_rd_keep got %0d want 5", rf_rd); end
  endtask
  task automatic test_contention;
    // pointer sits at 1 after the single write from requester 0
    logic [1:0] exp_ready [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    logic [4:0] exp_rd [4] = '{5'd4, 5'd3, 5'd4, 5'd3};
    req_valid = 2'b11;
    rd0 = 5'd3;
    rd1 = 5'd4;
    d0 = 32'h0000_0333;
    d1 = 32'h0000_0444;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (req_ready !== exp_ready[i]) begin errors++; $display("FAIL contention_ready[%0d] got %b want %b", i, req_ready, exp_ready[i]); end
      tick();
      checks++; if (rf_rd !== exp_rd[i] || rf_we !== 1'b1) begin errors++; $display("FAIL contention_rd[%0d] got %0d we %b want %0d we 1", i, rf_rd, rf_we, exp_rd[i]); end
    end
    req_valid = 2'b00;
    tick();
  endtask
  task automatic test_x0;
    req_valid = 2'b10;
    rd1 = 5'd0;
    d1 = 32'hFFFFFFFF;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL x0_ready got %b want 10", req_ready); end
    tick();
    req_valid = 2'b00;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_we got %b want 0", rf_we); end
    checks++; if (rf_rd !== 5'd0) begin errors++; $display("FAIL x0_rd got %0d want 0", rf_rd); end
  endtask
  task automatic test_forward;
    req_valid = 2'b01;
    rd0 = 5'd7;
    d0 = 32'hAA;
    tick();
    req_valid = 2'b00;
    rs_addr = 5'd7;
    rt_addr = 5'd0;
    rf_rs_data = 32'h11;
    rf_rt_data = 32'h22;
    #1;
    checks++; if (rs_data !== 32'hAA) begin errors++; $display("FAIL fwd_rs got %h want aa", rs_data); end
    checks++; if (rt_data !== 32'h22) begin errors++; $display("FAIL fwd_rt_x0 got %h want 22", rt_data); end
    rs_addr = 5'd6;
    rt_addr = 5'd7;
    #1;
    checks++; if (rs_data !== 32'h11) begin errors++; $display("FAIL fwd_rs_miss got %h want 11", rs_data); end
    checks++; if (rt_data !== 32'hAA) begin errors++; $display("FAIL fwd_rt got %h want aa", rt_data); end
    tick();
    checks++; if (rt_data !== 32'h22) begin errors++; $display("FAIL fwd_rt_idle got %h want 22", rt_data); end
  endtask
  task automatic test_hold;
    // pointer is 1 here; both valid, so the release grant proves it did not move
    wb_hold = 1'b1;
    req_valid = 2'b11;
    rd1 = 5'd9;
    d1 = 32'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL hold_ready[%0d] got %b want 00", i, req_ready); end
      tick();
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL hold_we[%0d] got %b want 0", i, rf_we); end
    end
    wb_hold = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL hold_release got %b want 10", req_ready); end
    tick();
    req_valid = 2'b00;
    wb_hold = 1'b1;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd9 || rf_wdata !== 32'h55) begin errors++; $display("FAIL hold_commit got we %b rd %0d data %h want 1 9 55", rf_we, rf_rd, rf_wdata); end
    tick();
    wb_hold = 1'b0;
  endtask
`ifdef WB_STATS_EN
  task automatic test_stats;
    checks++; if (stat_commits !== 32'd7) begin errors++; $display("FAIL stat_commits got %0d want 7", stat_commits); end
    checks++; if (stat_conflicts !== 32'd5) begin errors++; $display("FAIL stat_conflicts got %0d want 5", stat_conflicts); end
    checks++; if (stat_x0_drops !== 32'd1) begin errors++; $display("FAIL stat_x0_drops got %0d want 1", stat_x0_drops); end
  endtask
`endif
  task automatic test_reset_mid;
    req_valid = 2'b01;
    rd0 = 5'd10;
    d0 = 32'h77;
    tick();
    req_valid = 2'b00;
    #1;
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL rstmid_pre_we got %b want 1", rf_we); end
    rst = 1'b1;
    tick();
    checks++; if (rf_we !== 1'b0 || rf_rd !== 5'd0) begin errors++; $display("FAIL rstmid_we got we %b rd %0d want 0 0", rf_we, rf_rd); end
    rst = 1'b0;
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_ptr got %b want 01", req_ready); end
    req_valid = 2'b00;
    tick();
  endtask
  initial begin
    test_reset();
    test_single();
    test_contention();
    test_x0();
    test_forward();
    test_hold();
`ifdef WB_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
